ins_mem_loader: RTL and testbench
=================================

Name: ins_mem_loader

Overview:
Byte-stream programmer that fills the processor's instruction memory, i.e. the write side of the instruction-memory interface.
- Accepts a length-prefixed little-endian byte stream (typically from the UART receiver) over a valid/ready handshake.
- Assembles bytes into INSTRUCTION_WIDTH-bit words and issues one write per word with a word-aligned byte address.
- Holds the core in reset via busy while loading.

Parameters:
INSTRUCTION_WIDTH, 32, width of one instruction word; must be a multiple of 8
MEMORY_DEPTH, 256, number of words in instruction memory; caps writes
PC_WIDTH, 32, width of wr_address; byte address, same addressing as the PC

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a load; ignored while busy
rx_data  input  8  incoming stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_address  output  PC_WIDTH  byte address of word; low 2 bits always 0
wr_data  output  INSTRUCTION_WIDTH  assembled instruction word
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when load completes
error  output  1  sticky fault flag, cleared on next accepted start

Behaviour:
- Reset (async, rstN=0): state IDLE; all outputs 0; address counter 0; byte index 0; word count 0.
- Byte accepted on a rising edge with rx_valid && rx_ready.
- rx_ready is high only in LEN_LO, LEN_HI and DATA.
- rx_valid may drop between bytes at any time; no bytes are lost or duplicated.
- States:
  - IDLE: start → LEN_LO, busy=1, error cleared, address counter 0.
  - LEN_LO: accept byte → N[7:0]; go to LEN_HI.
  - LEN_HI: accept byte → N[15:8]. If N==0, go to DONE. Otherwise go to DATA. If N > MEMORY_DEPTH, set error=1.
  - DATA: bytes assembled little-endian; the first byte of a word goes to bits [7:0].
    - After byte INSTRUCTION_WIDTH/8 of a word is accepted, the next cycle has wr_en=1 with the registered wr_data and wr_address.
    - The address counter then advances by INSTRUCTION_WIDTH/8.
    - rx_ready stays high during the write cycle, so full-rate streams are sustained.
    - After N words have been consumed, go to DONE.
  - DONE: done=1 and busy=0 for one cycle; next state IDLE.
- Overflow (N > MEMORY_DEPTH):
  - Only the first MEMORY_DEPTH words are written; the last write is at (MEMORY_DEPTH-1)*4.
  - Remaining words are consumed with wr_en held 0.
- wr_address/wr_data hold their last values when wr_en=0.
- wr_address width: the counter wraps modulo 2^PC_WIDTH, but is never reached past the cap.
- start during busy: ignored, no effect on state or error.
- Reset mid-load: immediate abort to reset values. Partially written memory is not restored; a fresh start reloads from address 0.
- Word count is 16 bits; N up to 65535 is legal (overflow rules apply).

Optional Feature:
INS_LOADER_CHECKSUM_EN:
- Defined:
  - A CHK state follows the last data word; rx_ready is high in CHK.
  - One trailing byte is accepted there. It must equal the XOR of all data bytes, including discarded overflow bytes.
  - On a mismatch, error=1. The state then goes to DONE.
- Undefined: no CHK state; DATA goes directly to DONE; no trailing byte is consumed.

Test Plan:
1. Reset, then hold rstN=0 while toggling start/rx_valid → all outputs 0, rx_ready=0.
2. start, then continuous bytes 02 00 13 00 00 00 93 00 A0 00 → wr_en at addr 0x0 data 0x00000013, then addr 0x4 data 0x00A00093; done pulse 1 cycle after the second write; error=0.
3. start, bytes 00 00 → no wr_en; done pulses the cycle after the LEN_HI byte is accepted; busy falls with done.
4. Same stream as test 2 with 1–5 random idle cycles between bytes, plus start pulsed mid-load → identical writes, start ignored.
5. MEMORY_DEPTH=256, N=257 (01 01), then 1028 bytes → exactly 256 writes, last at 0x3FC; error=1; done after the 1028th byte.
6. rstN asserted after 2 DATA bytes, then released; start, 01 00 EF BE AD DE → a single write at addr 0x0 with data 0xDEADBEEF.

Source files
------------

// File: rtl/ins_mem_loader.sv
// rtl/ins_mem_loader.sv - length-prefixed byte stream to instruction-memory writer (option: INS_LOADER_CHECKSUM_EN)
module ins_mem_loader #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MEMORY_DEPTH      = 256,
    parameter int PC_WIDTH          = 32
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         start,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         rx_ready,
    output logic                         wr_en,
    output logic [PC_WIDTH-1:0]          wr_address,
    output logic [INSTRUCTION_WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);
    localparam int BYTES = INSTRUCTION_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BYTES - 1);
    localparam logic [PC_WIDTH-1:0] ADDR_STEP = PC_WIDTH'(BYTES);
    // Depth clamped to what a 16-bit word count can ever exceed.
    localparam logic [16:0] DEPTH_CAP = (MEMORY_DEPTH > 65536) ? 17'd65536 : 17'(MEMORY_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
`ifdef INS_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK    = 3'd4;
`endif
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]                   state_q, state_d;
    logic [15:0]                  n_q, n_d;
    logic [15:0]                  word_cnt_q, word_cnt_d;
    logic [IDX_W-1:0]             byte_idx_q, byte_idx_d;
    logic [INSTRUCTION_WIDTH-1:0] word_q, word_d;
    logic [PC_WIDTH-1:0]          addr_q, addr_d;
    logic                         wr_en_q, wr_en_d;
    logic [PC_WIDTH-1:0]          wr_address_q, wr_address_d;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                         error_q, error_d;
    logic [INSTRUCTION_WIDTH-1:0] assembled;
    logic                         ready_c;
`ifdef INS_LOADER_CHECKSUM_EN
    logic [7:0]                   chk_q, chk_d;
`endif

    // Next-state logic: length capture, little-endian word assembly, capped writes.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        word_cnt_d   = word_cnt_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        error_d      = error_q;
        ready_c      = 1'b0;
        // New byte enters at the top; after BYTES shifts the first byte sits in [7:0].
        assembled    = (word_q >> 8) | (INSTRUCTION_WIDTH'(rx_data) << (INSTRUCTION_WIDTH - 8));
`ifdef INS_LOADER_CHECKSUM_EN
        chk_d        = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    error_d    = 1'b0;
                    addr_d     = '0;
                    word_cnt_d = '0;
                    byte_idx_d = '0;
                    n_d        = '0;
`ifdef INS_LOADER_CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            S_LEN_LO: begin
                ready_c = 1'b1;
                if (rx_valid) begin
                    n_d[7:0] = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                ready_c = 1'b1;
                if (rx_valid) begin
                    n_d[15:8] = rx_data;
                    state_d   = ({rx_data, n_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
                    if ({1'b0, rx_data, n_q[7:0]} > DEPTH_CAP) begin
                        error_d = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (word_cnt_q == n_q) begin
                    // Final write cycle: nothing more to take from the stream.
`ifdef INS_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    ready_c = 1'b1;
                    if (rx_valid) begin
`ifdef INS_LOADER_CHECKSUM_EN
                        chk_d = chk_q ^ rx_data;
`endif
                        word_d = assembled;
                        if (byte_idx_q == LAST_IDX) begin
                            byte_idx_d = '0;
                            word_cnt_d = word_cnt_q + 16'd1;
                            if ({1'b0, word_cnt_q} < DEPTH_CAP) begin
                                wr_en_d      = 1'b1;
                                wr_address_d = addr_q;
                                wr_data_d    = assembled;
                                addr_d       = addr_q + ADDR_STEP;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + IDX_W'(1);
                        end
                    end
                end
            end
`ifdef INS_LOADER_CHECKSUM_EN
            S_CHK: begin
                ready_c = 1'b1;
                if (rx_valid) begin
                    if (rx_data != chk_q) begin
                        error_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            error_q      <= 1'b0;
`ifdef INS_LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            error_q      <= error_d;
`ifdef INS_LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign rx_ready   = ready_c;
    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = error_q;
endmodule

// File: tb/tb_ins_mem_loader.sv
// tb/tb_ins_mem_loader.sv - scoreboard bench for ins_mem_loader
module tb_ins_mem_loader;
    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_address;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    ins_mem_loader #(
        .INSTRUCTION_WIDTH(32),
        .MEMORY_DEPTH     (256),
        .PC_WIDTH         (32)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        int          acc_gap;
        int          wr_gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec  = 0;
    int  n_miss = 0;
    int  cyc    = 0;
    int  last_acc = 0;
    int  last_wr  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.err = 1'b0; e.acc_gap = 0; e.wr_gap = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic err, input int acc_gap, input int wr_gap);
        ev_t e;
        e.is_done = 1'b1; e.addr = '0; e.data = '0; e.err = err; e.acc_gap = acc_gap; e.wr_gap = wr_gap;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected event for every write strobe or done pulse.
    always @(negedge clk) begin
        ev_t e;
        if (wr_en || done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, wr_en, done}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                if (wr_en) begin
                    check("event_kind_wr", 64'(e.is_done), 64'd0);
                    check("wr_address", 64'(wr_address), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                    last_wr = cyc;
                end else begin
                    check("event_kind_done", 64'(e.is_done), 64'd1);
                    check("done_error", 64'(error), 64'(e.err));
                    check("done_busy", 64'(busy), 64'd0);
                    if (e.acc_gap != 0) check("done_after_byte", 64'(cyc - last_acc), 64'(e.acc_gap));
                    if (e.wr_gap != 0) check("done_after_write", 64'(cyc - last_wr), 64'(e.wr_gap));
                end
            end
        end
        if (rx_valid && rx_ready) last_acc = cyc;
    end

    // Entered and left at posedge+1.
    task automatic send_byte(input logic [7:0] b, input int idle, input bit pulse_start);
        int guard;
        for (int i = 0; i < idle; i++) begin
            rx_valid = 1'b0;
            start = pulse_start && (i == 0);
            @(posedge clk); #1;
        end
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        forever begin
            @(negedge clk);
            if (rx_ready) break;
            guard++;
            if (guard > 100) begin
                check("rx_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        int guard;
        guard = 0;
        while ((busy || done) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_address"}, 64'(wr_address), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    logic [7:0] s2 [10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s2 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
        rstN = 1'b0; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;

        // Test 1: reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = i[0]; rx_valid = ~i[0]; rx_data = 8'(8'h5A + i);
            @(negedge clk);
            check_idle_outputs("reset");
        end
        start = 1'b0; rx_valid = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        check("idle_rx_ready", 64'(rx_ready), 64'd0);

        // Test 2: two-word load at full rate.
        push_wr(32'h0, 32'h00000013);
        push_wr(32'h4, 32'h00A00093);
        push_done(1'b0, 2, 1);
        do_start();
        check("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) send_byte(s2[i], 0, 1'b0);
        drain("t2_drain");

        // Test 3: zero-length load.
        push_done(1'b0, 1, 0);
        do_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        drain("t3_drain");

        // Test 4: gapped stream with a stray start mid-load.
        push_wr(32'h0, 32'h00000013);
        push_wr(32'h4, 32'h00A00093);
        push_done(1'b0, 2, 1);
        do_start();
        for (int i = 0; i < 10; i++) send_byte(s2[i], int'($urandom_range(1, 5)), i == 5);
        drain("t4_drain");

        // Test 5: N=257 overflows a 256-word memory.
        for (int w = 0; w < 256; w++) begin
            push_wr(32'(4 * w), {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)});
        end
        push_done(1'b1, 2, 0);
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        for (int i = 0; i < 1028; i++) send_byte(8'(i), 0, 1'b0);
        drain("t5_drain");
        repeat (2) @(posedge clk);
        #1;
        check("error_sticky", 64'(error), 64'd1);

        // Test 6: next start clears error; reset mid-load; reload from 0.
        do_start();
        @(negedge clk);
        check("error_cleared_on_start", 64'(error), 64'd0);
        @(posedge clk); #1;
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        rstN = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_idle_outputs("abort");
        rstN = 1'b1;
        @(posedge clk); #1;
        push_wr(32'h0, 32'hDEADBEEF);
        push_done(1'b0, 2, 1);
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hEF, 0, 1'b0);
        send_byte(8'hBE, 0, 1'b0);
        send_byte(8'hAD, 0, 1'b0);
        send_byte(8'hDE, 0, 1'b0);
        drain("t6_drain");

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
